mioc_dram_seq: RTL
==================

Name: mioc_dram_seq

Overview:
- DRAM strobe sequencer for the MIOC.
- Turns buffered Z80 memory-cycle signals (BMREQ_N, BRD_N, N_BWR, BRFSH_N) into the RAS_N, MUX, CAS1_N, CAS2_N and RA7 waveforms that the top level drives on pins 37-40 and pin 2.
- Sits directly upstream of the top-level DRAM pins, next to the address decode (MEM_EN) and the flop bank.
- Runs RAS-only refresh and extends the Z80's 7-bit refresh address to 8 rows through RA7.

Parameters:
- RAS_TO_MUX, 1, B_PHI cycles from RAS_N low to MUX high (legal 1..8)
- MUX_TO_CAS, 1, minimum B_PHI cycles from MUX high to CAS low (legal 1..8)
- PRECHARGE, 2, B_PHI cycles all strobes held high after a cycle (legal 1..8)
- RFSH_RAS, 2, minimum RAS_N low cycles for a refresh (legal 1..8)

Ports:
- B_PHI  input  1  Z80 clock; all state changes on its rising edge
- RST  input  1  asynchronous, active-high reset
- BMREQ_N  input  1  buffered memory request, active low
- BRFSH_N  input  1  buffered refresh, active low
- BRD_N  input  1  buffered read, active low
- N_BWR  input  1  buffered write, active low
- MEM_EN  input  1  high when the decoded address targets DRAM (not boot or aux ROM)
- BA7  input  1  address bit 7 (row MSB)
- BA14  input  1  address bit 14 (column MSB)
- BA15  input  1  bank select: 0 selects CAS1_N, 1 selects CAS2_N
- RAS_N  output  1  row address strobe, registered
- MUX  output  1  row/column mux select, registered (0 = row)
- CAS1_N  output  1  column strobe, bank 0, registered
- CAS2_N  output  1  column strobe, bank 1, registered
- RA7  output  1  multiplexed RAM address MSB, combinational

Behaviour:
- Reset (async, RST=1): state IDLE; RAS_N=1, CAS1_N=1, CAS2_N=1, MUX=0; cnt=0; bank=0; rfsh_cnt=0; rfsh_msb=0.
- Reset asserted mid-cycle deasserts every strobe immediately, without waiting for a clock edge.
- cnt is 3 bits and holds parameter-1 on load.
- States: IDLE, ROW, COL, CAS, RFSH, PRE.
- IDLE:
  - BMREQ_N=0 and BRFSH_N=0 -> RFSH; RAS_N<=0; cnt<=RFSH_RAS-1; rfsh_cnt<=rfsh_cnt+1; rfsh_msb toggles when rfsh_cnt wraps 127->0.
  - Else BMREQ_N=0 and MEM_EN=1 -> ROW; RAS_N<=0; bank<=BA15; cnt<=RAS_TO_MUX-1.
  - Refresh has priority over an access.
  - BMREQ_N=0 with MEM_EN=0 -> remain in IDLE, no strobes.
- ROW: cnt==0 -> COL, MUX<=1, cnt<=MUX_TO_CAS-1; otherwise cnt decrements.
- COL:
  - BMREQ_N=1 at any point -> PRE (abort; no CAS issued).
  - cnt==0 and (BRD_N=0 or N_BWR=0) -> CAS; CAS1_N<=0 if bank=0, else CAS2_N<=0.
  - cnt==0 and neither strobe low -> hold in COL (late-write support).
  - cnt!=0 -> cnt decrements.
- CAS: hold all strobes until BMREQ_N=1, then -> PRE.
- RFSH: hold RAS_N=0 while cnt!=0 (decrement) or while BMREQ_N=0; at cnt==0 and BMREQ_N=1 -> PRE.
- PRE:
  - On entry: RAS_N, CAS1_N, CAS2_N <=1; MUX<=0; cnt<=PRECHARGE-1.
  - At cnt==0 -> IDLE.
  - A request asserted during PRE is not lost: IDLE samples the BMREQ_N level on the following edge.
- Every exit to PRE requires BMREQ_N=1, so a single held request can never start two cycles.
- Only one CAS is ever low. The bank is latched at ROW entry; BA15 changes after that are ignored.
- RA7: rfsh_msb in RFSH; BA7 when MUX=0; BA14 when MUX=1.
- Minimum access, default parameters, read already low: RAS at edge 0, MUX at edge 1, CAS at edge 2.

Optional Feature:
- Macro MIOC_DRAM_WAIT_EN.
- When defined: adds output WAIT_REQ_N (1 bit, reset 1).
  - Registered low while in PRE with BMREQ_N=0 and MEM_EN=1.
  - Returns high on the edge the sequencer leaves IDLE for ROW or RFSH.
- When undefined: the port is absent and there is no added logic.

Test Plan:
- Read, defaults: BMREQ_N=0, MEM_EN=1, BA15=0, BRD_N=0 at edge 0 -> RAS_N low at edge 0, MUX high at 1, CAS1_N low at 2; BMREQ_N=1 -> all high next edge, IDLE 2 edges later.
- Late write, BA15=1: N_BWR held high 3 extra cycles -> sequencer holds COL, CAS2_N low the edge after N_BWR=0, CAS1_N stays 1 throughout.
- Refresh x128: 128 RAS-only refresh cycles (BRFSH_N=0) -> MUX and CASes never assert, RA7=0 for cycles 1-127, RA7=1 on cycle 128 (rfsh_cnt wrap toggles rfsh_msb).
- Abort in COL: BMREQ_N rises while in COL with BRD_N=1 -> PRE, no CAS pulse, MUX 0 on the PRE edge.
- Async reset mid-CAS: RST=1 while CAS1_N=0 -> RAS_N, CAS1_N, MUX return to reset values before the next B_PHI edge; after release, the first request starts a clean cycle.
- MIOC_DRAM_WAIT_EN: new request during PRE -> WAIT_REQ_N=0 until ROW entry; with the macro undefined, the build has no WAIT_REQ_N port.

Source files
------------

// File: rtl/mioc_dram_seq.sv
// mioc_dram_seq: MIOC DRAM RAS/MUX/CAS sequencer with RAS-only refresh; `MIOC_DRAM_WAIT_EN adds WAIT_REQ_N
module mioc_dram_seq #(
  parameter int RAS_TO_MUX = 1,
  parameter int MUX_TO_CAS = 1,
  parameter int PRECHARGE  = 2,
  parameter int RFSH_RAS   = 2
) (
  input  logic B_PHI,
  input  logic RST,
  input  logic BMREQ_N,
  input  logic BRFSH_N,
  input  logic BRD_N,
  input  logic N_BWR,
  input  logic MEM_EN,
  input  logic BA7,
  input  logic BA14,
  input  logic BA15,
  output logic RAS_N,
  output logic MUX,
  output logic CAS1_N,
  output logic CAS2_N,
`ifdef MIOC_DRAM_WAIT_EN
  output logic WAIT_REQ_N,
`endif
  output logic RA7
);
  typedef enum logic [2:0] {IDLE, ROW, COL, CAS, RFSH, PRE} state_t;
  localparam logic [2:0] RAS_TO_MUX_L = 3'(RAS_TO_MUX - 1);
  localparam logic [2:0] MUX_TO_CAS_L = 3'(MUX_TO_CAS - 1);
  localparam logic [2:0] PRECHARGE_L  = 3'(PRECHARGE - 1);
  localparam logic [2:0] RFSH_RAS_L   = 3'(RFSH_RAS - 1);
  state_t state_q, state_d;
  logic ras_n_q, ras_n_d, mux_q, mux_d, cas1_n_q, cas1_n_d, cas2_n_q, cas2_n_d;
  logic bank_q, bank_d, rfsh_msb_q, rfsh_msb_d, go_pre;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rfsh_cnt_q, rfsh_cnt_d;
`ifdef MIOC_DRAM_WAIT_EN
  logic wait_req_n_q, wait_req_n_d;
`endif
  // next-state and strobe computation; every exit to PRE is funnelled through go_pre
  always_comb begin
    state_d = state_q;
    ras_n_d = ras_n_q;
    mux_d = mux_q;
    cas1_n_d = cas1_n_q;
    cas2_n_d = cas2_n_q;
    bank_d = bank_q;
    cnt_d = cnt_q;
    rfsh_cnt_d = rfsh_cnt_q;
    rfsh_msb_d = rfsh_msb_q;
    go_pre = 1'b0;
    case (state_q)
      IDLE:
        if (!BMREQ_N && !BRFSH_N) begin
          state_d = RFSH;
          ras_n_d = 1'b0;
          cnt_d = RFSH_RAS_L;
          rfsh_cnt_d = rfsh_cnt_q + 7'd1;
          rfsh_msb_d = rfsh_msb_q ^ (&rfsh_cnt_q);
        end else if (!BMREQ_N && MEM_EN) begin
          state_d = ROW;
          ras_n_d = 1'b0;
          bank_d = BA15;
          cnt_d = RAS_TO_MUX_L;
        end
      ROW:
        if (cnt_q == 3'd0) begin
          state_d = COL;
          mux_d = 1'b1;
          cnt_d = MUX_TO_CAS_L;
        end else cnt_d = cnt_q - 3'd1;
      COL:
        if (BMREQ_N) go_pre = 1'b1;
        else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else if (!BRD_N || !N_BWR) begin
          state_d = CAS;
          cas1_n_d = bank_q;
          cas2_n_d = !bank_q;
        end
      CAS: go_pre = BMREQ_N;
      RFSH:
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else go_pre = BMREQ_N;
      PRE:
        if (cnt_q == 3'd0) state_d = IDLE;
        else cnt_d = cnt_q - 3'd1;
      default: state_d = IDLE;
    endcase
    if (go_pre) begin
      state_d = PRE;
      ras_n_d = 1'b1;
      mux_d = 1'b0;
      cas1_n_d = 1'b1;
      cas2_n_d = 1'b1;
      cnt_d = PRECHARGE_L;
    end
  end
`ifdef MIOC_DRAM_WAIT_EN
  // hold off a DRAM request that arrives during precharge until the sequencer can start it
  always_comb begin
    wait_req_n_d = wait_req_n_q;
    if (state_q == PRE && !BMREQ_N && MEM_EN) wait_req_n_d = 1'b0;
    if (state_q == IDLE && state_d != IDLE) wait_req_n_d = 1'b1;
  end
  // wait request register
  always_ff @(posedge B_PHI or posedge RST)
    if (RST) wait_req_n_q <= 1'b1;
    else wait_req_n_q <= wait_req_n_d;
  assign WAIT_REQ_N = wait_req_n_q;
`endif
  // sequencer state and registered strobes; reset drops every strobe immediately
  always_ff @(posedge B_PHI or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      ras_n_q <= 1'b1;
      mux_q <= 1'b0;
      cas1_n_q <= 1'b1;
      cas2_n_q <= 1'b1;
      bank_q <= 1'b0;
      cnt_q <= 3'd0;
      rfsh_cnt_q <= 7'd0;
      rfsh_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ras_n_q <= ras_n_d;
      mux_q <= mux_d;
      cas1_n_q <= cas1_n_d;
      cas2_n_q <= cas2_n_d;
      bank_q <= bank_d;
      cnt_q <= cnt_d;
      rfsh_cnt_q <= rfsh_cnt_d;
      rfsh_msb_q <= rfsh_msb_d;
    end
  assign RAS_N = ras_n_q;
  assign MUX = mux_q;
  assign CAS1_N = cas1_n_q;
  assign CAS2_N = cas2_n_q;
  assign RA7 = (state_q == RFSH) ? rfsh_msb_q : (mux_q ? BA14 : BA7);
endmodule
